// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch predictor.
// Holds the 2-bit counter type, its named states and the default parameters.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'd0;
    localparam ctr_t CTR_WNT = 2'd1;
    localparam ctr_t CTR_WT  = 2'd2;
    localparam ctr_t CTR_ST  = 2'd3;

    localparam int ENTRIES_DEF = 16;
    localparam int PC_W_DEF    = 32;
    localparam int HIST_W_DEF  = 4;

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a 2-bit saturating direction counter.
// Ports: cur (current value), taken (outcome), nxt (next value).
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t cur,
    input  logic taken,
    output ctr_t nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != CTR_ST)
                nxt = cur + 2'd1;
        end else begin
            if (cur != CTR_SNT)
                nxt = cur - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// BTB with 2-bit counters; 1-cycle registered lookup, update from execute.
// Ports: clk, rst (sync high), fetch_* lookup in, pred_* out, upd_* in,
// mispredict out. Macro BRANCH_PRED_GSHARE_EN adds a gshare pattern table.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int PC_W    = PC_W_DEF,
    parameter int HIST_W  = HIST_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_valid,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    output logic            pred_hit,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_is_branch,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred_taken,
    output logic            mispredict
);

    localparam int IDXW  = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDXW - 2;

    typedef logic [IDXW-1:0]  idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    logic            ent_v   [ENTRIES];
    tag_t            ent_tag [ENTRIES];
    logic [PC_W-1:0] ent_tgt [ENTRIES];
    ctr_t            ctr_tab [ENTRIES];

    idx_t f_idx, u_idx, f_cidx, u_cidx;
    tag_t f_tag, u_tag;
    logic f_hit, u_hit, u_commit;
    ctr_t u_nxt;
    logic unused_ok;

    assign f_idx = fetch_pc[IDXW+1:2];
    assign u_idx = upd_pc[IDXW+1:2];
    assign f_tag = fetch_pc[PC_W-1:IDXW+2];
    assign u_tag = upd_pc[PC_W-1:IDXW+2];

    assign unused_ok = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign f_hit    = ent_v[f_idx] && (ent_tag[f_idx] == f_tag);
    assign u_hit    = ent_v[u_idx] && (ent_tag[u_idx] == u_tag);
    assign u_commit = upd_valid && upd_is_branch;

`ifdef BRANCH_PRED_GSHARE_EN
    logic [HIST_W-1:0] ghr;

    // Counters are hashed with global history; tags/targets are not.
    assign f_cidx = f_idx ^ idx_t'(ghr);
    assign u_cidx = u_idx ^ idx_t'(ghr);

    always_ff @(posedge clk) begin
        if (rst)
            ghr <= '0;
        else if (u_commit)
            ghr <= HIST_W'({ghr, upd_taken});
    end
`else
    assign f_cidx = f_idx;
    assign u_cidx = u_idx;
`endif

    bp_sat_counter u_sat (
        .cur   (ctr_tab[u_cidx]),
        .taken (upd_taken),
        .nxt   (u_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
            pred_hit    <= 1'b0;
            mispredict  <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_v[i]   <= 1'b0;
                ent_tag[i] <= '0;
                ent_tgt[i] <= '0;
                ctr_tab[i] <= CTR_WNT;
            end
        end else begin
            // Lookup reads pre-update state: no bypass.
            pred_valid  <= fetch_valid;
            pred_hit    <= fetch_valid && f_hit;
            pred_taken  <= fetch_valid && f_hit &&
                           ctr_tab[f_cidx][1];
            pred_target <= (fetch_valid && f_hit) ?
                           ent_tgt[f_idx] : '0;
            mispredict  <= u_commit &&
                           (upd_taken != upd_pred_taken);
            if (u_commit) begin
                if (u_hit) begin
                    ctr_tab[u_cidx] <= u_nxt;
                    if (upd_taken)
                        ent_tgt[u_idx] <= upd_target;
                end else if (upd_taken) begin
                    ent_v[u_idx]    <= 1'b1;
                    ent_tag[u_idx]  <= u_tag;
                    ent_tgt[u_idx]  <= upd_target;
                    ctr_tab[u_cidx] <= CTR_WT;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor against a behavioural model.
// Directed scenarios, alternating-pattern test, then random traffic.
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int PC_W    = 32;
    localparam int HIST_W  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            fetch_valid;
    logic [PC_W-1:0] fetch_pc;
    logic            pred_valid;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            pred_hit;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_is_branch;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            upd_pred_taken;
    logic            mispredict;

    int total = 0;
    int bad   = 0;

    branch_predictor #(
        .ENTRIES (ENTRIES),
        .PC_W    (PC_W),
        .HIST_W  (HIST_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .pred_valid     (pred_valid),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_hit       (pred_hit),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_is_branch  (upd_is_branch),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_pred_taken (upd_pred_taken),
        .mispredict     (mispredict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain arrays keyed by (pc/4) mod ENTRIES.
    bit          m_v   [ENTRIES];
    int unsigned m_tag [ENTRIES];
    int unsigned m_tgt [ENTRIES];
    int          m_ctr [ENTRIES];
    int unsigned m_hist;

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_v[i]   = 0;
            m_tag[i] = 0;
            m_tgt[i] = 0;
            m_ctr[i] = 1;
        end
        m_hist = 0;
    endfunction

    function automatic int unsigned idx_of(input int unsigned pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic int unsigned cidx_of(input int unsigned pc);
`ifdef BRANCH_PRED_GSHARE_EN
        return idx_of(pc) ^ (m_hist % (1 << HIST_W));
`else
        return idx_of(pc);
`endif
    endfunction

    task automatic cycle(input bit r, input bit fv,
                         input int unsigned fpc,
                         input bit uv, input bit ub, input bit ut,
                         input int unsigned upc,
                         input int unsigned utg, input bit upt);
        bit          e_pv, e_ph, e_pt, e_mp, hit;
        int unsigned e_tg, fi, ui, uc;
        rst            = r;
        fetch_valid    = fv;
        fetch_pc       = fpc;
        upd_valid      = uv;
        upd_is_branch  = ub;
        upd_taken      = ut;
        upd_pc         = upc;
        upd_target     = utg;
        upd_pred_taken = upt;
        e_pv = 0; e_ph = 0; e_pt = 0; e_mp = 0; e_tg = 0;
        if (r) begin
            m_reset();
        end else begin
            fi   = idx_of(fpc);
            hit  = fv && m_v[fi] && (m_tag[fi] == tag_of(fpc));
            e_pv = fv;
            e_ph = hit;
            e_pt = hit && (m_ctr[cidx_of(fpc)] >= 2);
            e_tg = hit ? m_tgt[fi] : 0;
            e_mp = uv && ub && (ut != upt);
            if (uv && ub) begin
                ui = idx_of(upc);
                uc = cidx_of(upc);
                if (m_v[ui] && m_tag[ui] == tag_of(upc)) begin
                    if (ut) m_ctr[uc] = (m_ctr[uc] == 3) ? 3 : m_ctr[uc] + 1;
                    else    m_ctr[uc] = (m_ctr[uc] == 0) ? 0 : m_ctr[uc] - 1;
                    if (ut) m_tgt[ui] = utg;
                end else if (ut) begin
                    m_v[ui]   = 1;
                    m_tag[ui] = tag_of(upc);
                    m_tgt[ui] = utg;
                    m_ctr[uc] = 2;
                end
                m_hist = (m_hist * 2 + (ut ? 1 : 0)) % (1 << HIST_W);
            end
        end
        @(posedge clk);
        #1;
        chk("pred_valid",  {31'd0, pred_valid}, {31'd0, e_pv});
        chk("pred_hit",    {31'd0, pred_hit},   {31'd0, e_ph});
        chk("pred_taken",  {31'd0, pred_taken}, {31'd0, e_pt});
        chk("pred_target", pred_target,         e_tg);
        chk("mispredict",  {31'd0, mispredict}, {31'd0, e_mp});
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic fetch(input int unsigned pc);
        cycle(0, 1, pc, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input int unsigned pc, input bit t,
                       input int unsigned tg, input bit pt);
        cycle(0, 0, 0, 1, 1, t, pc, tg, pt);
    endtask

    task automatic do_reset();
        cycle(1, 1, 32'h100, 1, 1, 1, 32'h100, 32'h700, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int mp, late_mp;
        bit p, t;
        int unsigned pc;
        rst = 1; fetch_valid = 0; fetch_pc = 0;
        upd_valid = 0; upd_pc = 0; upd_is_branch = 0;
        upd_taken = 0; upd_target = 0; upd_pred_taken = 0;

        do_reset();
        chk("rst_pv", {31'd0, pred_valid}, 32'd0);
        chk("rst_mp", {31'd0, mispredict}, 32'd0);

        fetch(32'h100);
        chk("cold_pv",  {31'd0, pred_valid}, 32'd1);
        chk("cold_hit", {31'd0, pred_hit},   32'd0);
        chk("cold_tgt", pred_target,         32'd0);

        upd(32'h100, 1, 32'h200, 0);
        chk("mp_pulse", {31'd0, mispredict}, 32'd1);
        idle();
        chk("mp_clear", {31'd0, mispredict}, 32'd0);
        fetch(32'h100);
        chk("alloc_hit", {31'd0, pred_hit}, 32'd1);
        chk("alloc_tgt", pred_target,       32'h200);
`ifndef BRANCH_PRED_GSHARE_EN
        chk("alloc_taken", {31'd0, pred_taken}, 32'd1);
`endif

        for (int i = 0; i < 4; i++) upd(32'h100, 0, 32'h0, 1);
        fetch(32'h100);
        chk("sat_hit", {31'd0, pred_hit}, 32'd1);
`ifndef BRANCH_PRED_GSHARE_EN
        chk("sat_taken", {31'd0, pred_taken}, 32'd0);
`endif

        cycle(0, 1, 32'h100, 1, 1, 1, 32'h100, 32'h300, 0);
        chk("nobypass_tgt", pred_target, 32'h200);
        fetch(32'h100);
        chk("after_tgt", pred_target, 32'h300);

        upd(32'h140, 1, 32'h500, 0);
        fetch(32'h100);
        chk("alias_miss", {31'd0, pred_hit}, 32'd0);
        fetch(32'h140);
        chk("alias_tgt", pred_target, 32'h500);

        cycle(0, 0, 0, 1, 0, 1, 32'h180, 32'h900, 0);
        chk("nonbr_mp", {31'd0, mispredict}, 32'd0);
        fetch(32'h180);
        chk("nonbr_miss", {31'd0, pred_hit}, 32'd0);

        do_reset();
        fetch(32'h140);
        chk("post_rst_miss", {31'd0, pred_hit}, 32'd0);

        do_reset();
        mp = 0;
        late_mp = 0;
        for (int i = 0; i < 16; i++) begin
            fetch(32'h100);
            p = pred_taken;
            t = (i % 2 == 0);
            upd(32'h100, t, 32'h200, p);
            if (p != t) begin
                mp++;
                if (i >= 8) late_mp++;
            end
        end
`ifdef BRANCH_PRED_GSHARE_EN
        chk("alt_late_mp", late_mp, 32'd0);
`else
        chk("alt_mp_half", {31'd0, (mp * 2 >= 16)}, 32'd1);
`endif

        for (int i = 0; i < 1500; i++) begin
            pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2);
            cycle(($urandom_range(0, 99) == 0),
                  $urandom_range(0, 1), pc,
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) != 0),
                  $urandom_range(0, 1),
                  ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2),
                  $urandom & 32'hffff_fffc,
                  $urandom_range(0, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, number of predictor entries; power of two, 4..256.
REQ-002 Parameter PC_W, default 32, program-counter width in bits.
REQ-003 Parameter HIST_W, default 4, global-history width in bits; HIST_W <= log2(ENTRIES).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 fetch_valid  input  1  lookup request this cycle.
REQ-007 fetch_pc  input  PC_W  address being fetched.
REQ-008 pred_valid  output  1  registered; prediction outputs valid.
REQ-009 pred_taken  output  1  registered; predicted direction.
REQ-010 pred_target  output  PC_W  registered; predicted target, 0 when no hit.
REQ-011 pred_hit  output  1  registered; tag matched a valid entry.
REQ-012 upd_valid  input  1  resolved-branch report from execute.
REQ-013 upd_pc  input  PC_W  address of the resolved instruction.
REQ-014 upd_is_branch  input  1  the resolved instruction is a conditional branch or jal.
REQ-015 upd_taken  input  1  actual outcome, the branch_or_not decision.
REQ-016 upd_target  input  PC_W  actual target.
REQ-017 upd_pred_taken  input  1  prediction that was carried down the pipe for this instruction.
REQ-018 mispredict  output  1  registered; one-cycle pulse requesting a flush.

Function
REQ-019 Each entry holds: valid, tag = pc[PC_W-1:IDXW+2], target[PC_W], and a 2-bit saturating counter; IDXW = log2(ENTRIES), and the BTB index is pc[IDXW+1:2].
REQ-020 Lookup latency is 1 cycle: pred_valid(t+1) = fetch_valid(t), and when fetch_valid(t)=0, all pred_* outputs are 0 at t+1.
REQ-021 pred_hit = entry valid and tag equal; pred_taken = pred_hit and counter >= 2; pred_target = entry target when pred_hit, else 0.
REQ-022 Counter encoding: 0 strong-not-taken, 1 weak-not-taken, 2 weak-taken, 3 strong-taken; a taken outcome increments the counter, saturating at 3, and a not-taken outcome decrements it, saturating at 0.
REQ-023 An update commits at the edge ending the cycle in which upd_valid and upd_is_branch are both 1; upd_valid with upd_is_branch=0 changes no state.
REQ-024 On a tag hit, the counter is updated per REQ-022, and the target is overwritten with upd_target when upd_taken=1.
REQ-025 On a miss with upd_taken=1, the entry is allocated or replaced: valid=1, new tag, target=upd_target, counter=2.
REQ-026 On a miss with upd_taken=0, no allocation takes place and the counter is unchanged.
REQ-027 mispredict(t+1) = upd_valid & upd_is_branch & (upd_taken != upd_pred_taken) at t.
REQ-028 When a lookup and an update hit the same index in the same cycle, the lookup returns the pre-update contents; there is no bypass.
REQ-029 Back-to-back updates to the same entry each apply in order with no lost update.

Reset
REQ-030 While rst=1: all valid bits are 0, all counters are 1, targets are 0, history is 0, and all outputs are 0 the following cycle.
REQ-031 Reset asserted mid-operation discards any in-flight lookup or update; the first lookup after deassertion misses.

Configuration
REQ-032 The feature is controlled by the macro BRANCH_PRED_GSHARE_EN.
REQ-033 With BRANCH_PRED_GSHARE_EN defined: counters live in a separate ENTRIES-deep pattern table, indexed by BTB index XOR zero-extended ghr. ghr is a HIST_W-bit register that shifts in upd_taken at every committed update (REQ-023). Tags and targets remain indexed per REQ-019.
REQ-034 Without BRANCH_PRED_GSHARE_EN: no history register exists, and counters are stored per entry at the BTB index.

Structure
REQ-035 Package bp_pkg holds the 2-bit counter typedef, the named constants for the four counter states, and the default parameter values.
REQ-036 Sub-module bp_sat_counter computes the saturating next-counter value from the current value and the outcome; it is instantiated once for the update path.

Verification
REQ-037 Reset, then fetch 0x100 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0.
REQ-038 Update pc 0x100, taken, target 0x200, pred_taken=0 -> mispredict pulses for 1 cycle; then fetch 0x100 -> hit=1, taken=1, target=0x200.
REQ-039 Four not-taken updates on 0x100 after REQ-038 -> counter 2->1->0->0 (saturates); fetch predicts not-taken with hit=1.
REQ-040 Same-cycle fetch and update of 0x100 (taken, target 0x300) -> lookup shows the old target 0x200; the next fetch shows 0x300.
REQ-041 Aliasing: pc 0x100 and 0x140 with ENTRIES=16 -> the second allocation replaces the first, and fetch 0x100 misses.
REQ-042 With GSHARE: alternating T/N on 0x100 for 16 updates -> after warm-up, predictions match outcomes; without GSHARE, the same stimulus gives at least 50% mispredicts.
